// File: rtl/uart_loader.sv
// Boot loader behind the UART receiver: parses a length/data/XOR-checksum frame,
// writes each 32-bit word to instruction memory and releases the CPU once verified.
module uart_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

    state_e             state_q, state_d;
    logic               ready_q;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        len_q, len_d;
    logic [31:0]        word_q, word_d;
    logic [7:0]         csum_q, csum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept_c;
    logic [31:0]        word_nxt_c;
    logic [31:0]        len_nxt_c;
    logic [CNT_W-1:0]   cnt_nxt_c;

    // Rising edge of the receiver's ready level marks a fresh byte.
    assign accept_c  = byte_ready_i & ~ready_q;
    assign len_nxt_c = {byte_i, len_q[31:8]};
    assign cnt_nxt_c = cnt_q + CNT_W'(1);

    always_comb begin
        word_nxt_c = word_q;
        word_nxt_c[{idx_q, 3'b000} +: 8] = byte_i;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        word_d  = word_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;
        wdata_d = wdata_q;

        if (accept_c) begin
            case (state_q)
                S_LEN: begin
                    len_d = len_nxt_c;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (len_nxt_c > MAX_WORDS)    state_d = S_ERR;
                        else if (len_nxt_c == 32'd0) state_d = S_CSUM;
                        else                          state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d = word_nxt_c;
                    csum_d = csum_q ^ byte_i;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_nxt_c;
                        cnt_d   = cnt_nxt_c;
                        if (32'(cnt_nxt_c) == len_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: state_d = (byte_i == csum_q) ? S_DONE : S_ERR;
                default: state_d = state_q;
            endcase
        end

        // Status flags follow the next state so they change with the transition.
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        hold_d = (state_d != S_DONE);
    end

    // Ready history resets high so a level already present at release is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LEN;
            ready_q <= 1'b1;
            idx_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= byte_ready_i;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_hold_o  = hold_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader: frames are sent byte by byte and
// memory writes are captured by a monitor for comparison with hand-computed values.
module tb_uart_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [7:0]        byte_i = 8'h00;
    logic              byte_ready_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          long_strobes = 0;
    logic        we_prev = 1'b0;

    uart_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .byte_i       (byte_i),
        .byte_ready_i (byte_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Capture write strobes mid-cycle and flag any strobe lasting over one cycle.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            wr_addr.push_back(32'(mem_addr_o));
            wr_data.push_back(mem_wdata_o);
            if (we_prev) long_strobes++;
        end
        we_prev = mem_we_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        byte_i       = b;
        byte_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        byte_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        long_strobes = 0;
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'd0);
            check({tag, "_d0"}, wr_data[0], 32'h0000_0013);
            check({tag, "_a1"}, wr_addr[1], 32'd1);
            check({tag, "_d1"}, wr_data[1], 32'h0010_0093);
        end
        check({tag, "_strobe"}, 32'(long_strobes), 32'd0);
    endtask

    logic [7:0] two_word[$] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        // Stale ready level present through reset release.
        byte_i       = 8'h05;
        byte_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_we",    32'(mem_we_o),    32'd0);
        check("rst_addr",  32'(mem_addr_o),  32'd0);
        check("rst_wdata", mem_wdata_o,      32'd0);
        check("rst_hold",  32'(cpu_hold_o),  32'd1);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_err",   32'(err_o),       32'd0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        byte_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_mon();
        send_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check("stale_done", 32'(done_o),          32'd1);
        check("stale_hold", 32'(cpu_hold_o),      32'd0);
        check("stale_nwr",  32'(wr_addr.size()),  32'd0);

        // Two-word load with good checksum.
        do_reset();
        clear_mon();
        send_frame(two_word);
        send_byte(8'h90);
        check_two_words("load");
        check("load_done", 32'(done_o),     32'd1);
        check("load_hold", 32'(cpu_hold_o), 32'd0);
        check("load_err",  32'(err_o),      32'd0);
        check("load_addr", 32'(mem_addr_o), 32'd2);
        send_byte(8'hAA);
        check("load_ignore", 32'(wr_addr.size()), 32'd2);

        // Zero length.
        do_reset();
        clear_mon();
        send_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check("zero_done", 32'(done_o),         32'd1);
        check("zero_nwr",  32'(wr_addr.size()), 32'd0);

        // Bad checksum.
        do_reset();
        clear_mon();
        send_frame(two_word);
        send_byte(8'h91);
        check_two_words("bad");
        check("bad_err",  32'(err_o),      32'd1);
        check("bad_hold", 32'(cpu_hold_o), 32'd1);
        check("bad_done", 32'(done_o),     32'd0);

        // Length overflow: N = 1025; err must appear right after the 4th byte.
        do_reset();
        clear_mon();
        send_frame('{8'h01, 8'h04, 8'h00});
        check("ovf_pre_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        byte_i       = 8'h00;
        byte_ready_i = 1'b1;
        @(negedge clk_i);
        check("ovf_err_t1", 32'(err_o),      32'd1);
        check("ovf_hold",   32'(cpu_hold_o), 32'd1);
        byte_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        send_frame('{8'h11, 8'h22, 8'h33, 8'h44});
        check("ovf_nwr",  32'(wr_addr.size()), 32'd0);
        check("ovf_done", 32'(done_o),         32'd0);

        // Reset in the middle of the second word, then a full resend.
        do_reset();
        clear_mon();
        send_frame('{8'h02, 8'h00, 8'h00, 8'h00,
                     8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00});
        check("mid_nwr",  32'(wr_addr.size()), 32'd1);
        check("mid_addr", 32'(mem_addr_o),     32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_addr",  32'(mem_addr_o),  32'd0);
        check("mid_rst_hold",  32'(cpu_hold_o),  32'd1);
        check("mid_rst_we",    32'(mem_we_o),    32'd0);
        check("mid_rst_wdata", mem_wdata_o,      32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        clear_mon();
        send_frame(two_word);
        send_byte(8'h90);
        check_two_words("reload");
        check("reload_done", 32'(done_o), 32'd1);
        check("reload_err",  32'(err_o),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
